// File: rtl/bitperm_arbiter.sv
// Two-requester round-robin arbiter in front of one shared bit-permutation unit
// with a one-deep result holding register. Optional per-requester job counters: BITPERM_ARB_STATS_EN.
module bitperm_arbiter #(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in0_valid,
    output logic          in0_ready,
    input  logic [W-1:0]  in0_data,
    input  logic [1:0]    in0_op,
    input  logic          in1_valid,
    output logic          in1_ready,
    input  logic [W-1:0]  in1_data,
    input  logic [1:0]    in1_op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_id
`ifdef BITPERM_ARB_STATS_EN
    ,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. Ready never depends on data; out_valid/out_data/out_id hold
    // steady until the consumer takes them.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_out_data;
    logic            r_out_id;
    logic            r_last;
    logic            w_grant1;
    logic            w_accept;
    logic            w_release;
    logic [W-1:0]    w_sel_data;
    logic [1:0]      w_sel_op;
    logic [W-1:0]    w_perm;

    function automatic logic [W-1:0] permute(input logic [W-1:0] d, input logic [1:0] op);
        logic [W-1:0] r;
        r = d;
        case (op)
            2'd0: r = d;
            2'd1: for (int k = 0; k < W; k++) r[k] = d[W-1-k];
            2'd2: r = {d[W/2-1:0], d[W-1:W/2]};
            default: begin
                for (int j = 0; j < W/2; j++) begin
                    r[2*j]   = d[2*j+1];
                    r[2*j+1] = d[2*j];
                end
            end
        endcase
        return r;
    endfunction

    // Requester 1 wins only when alone, or on a tie after requester 0 was served last.
    assign w_grant1   = in1_valid && (!in0_valid || !r_last);
    assign in0_ready  = (r_state == IDLE) && in0_valid && !w_grant1;
    assign in1_ready  = (r_state == IDLE) && w_grant1;
    assign w_accept   = in0_ready || in1_ready;
    assign w_release  = (r_state == HOLD) && out_ready;

    assign w_sel_data = w_grant1 ? in1_data : in0_data;
    assign w_sel_op   = w_grant1 ? in1_op   : in0_op;
    assign w_perm     = permute(w_sel_data, w_sel_op);

    assign out_valid  = (r_state == HOLD);
    assign out_data   = r_out_data;
    assign out_id     = r_out_id;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_state_nxt = HOLD;
            HOLD:    if (w_release) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_out_data <= '0;
            r_out_id   <= 1'b0;
            r_last     <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_out_data <= w_perm;
                r_out_id   <= w_grant1;
                r_last     <= w_grant1;
            end
        end
    end

`ifdef BITPERM_ARB_STATS_EN
    logic [CW-1:0] r_cnt0;
    logic [CW-1:0] r_cnt1;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_release) begin
            if (!r_out_id && (r_cnt0 != {CW{1'b1}})) r_cnt0 <= r_cnt0 + 1'b1;
            if (r_out_id  && (r_cnt1 != {CW{1'b1}})) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_bitperm_arbiter.sv
// Directed bench for bitperm_arbiter: handshake, round-robin, hold, reset and
// input-sampling scenarios with hand-computed results; counter checks with BITPERM_ARB_STATS_EN.
module tb_bitperm_arbiter;

    localparam int W = 8;
`ifdef BITPERM_ARB_STATS_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif

    logic          clk;
    logic          rst_n;
    logic          in0_valid, in0_ready;
    logic [W-1:0]  in0_data;
    logic [1:0]    in0_op;
    logic          in1_valid, in1_ready;
    logic [W-1:0]  in1_data;
    logic [1:0]    in1_op;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_data;
    logic          out_id;
`ifdef BITPERM_ARB_STATS_EN
    logic [CW-1:0] cnt0, cnt1;
`endif

    int n_checks;
    int n_pass;

    bitperm_arbiter #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in0_op    (in0_op),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .in1_op    (in1_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
`ifdef BITPERM_ARB_STATS_EN
        ,
        .cnt0      (cnt0),
        .cnt1      (cnt1)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic clear_inputs();
        in0_valid = 1'b0; in0_data = '0; in0_op = 2'd0;
        in1_valid = 1'b0; in1_data = '0; in1_op = 2'd0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_id", out_id, 1'b0);
`ifdef BITPERM_ARB_STATS_EN
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);
`endif
        rst_n = 1'b1;

        // Single requester, bit reverse of a palindrome
        in0_valid = 1'b1; in0_data = 8'b1000_0001; in0_op = 2'd1; out_ready = 1'b1;
        #1;
        check("t30_in0_ready", in0_ready, 1'b1);
        check("t30_in1_ready", in1_ready, 1'b0);
        check("t30_idle_valid", out_valid, 1'b0);
        @(negedge clk);
        in0_valid = 1'b0;
        check("t30_out_valid", out_valid, 1'b1);
        check("t30_out_data", out_data, 8'b1000_0001);
        check("t30_out_id", out_id, 1'b0);
        check("t30_hold_ready", in0_ready, 1'b0);
        @(negedge clk);
        check("t30_back_idle", out_valid, 1'b0);

        // Both valid: alternate grants, one result per two cycles
        do_reset();
        in0_valid = 1'b1; in0_data = 8'hA5; in0_op = 2'd2;
        in1_valid = 1'b1; in1_data = 8'h3C; in1_op = 2'd3;
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("t31_in0_ready", in0_ready, (i % 2) == 0);
            check("t31_in1_ready", in1_ready, (i % 2) == 1);
            @(negedge clk);
            check("t31_out_valid", out_valid, 1'b1);
            check("t31_out_id", out_id, (i % 2) == 1);
            check("t31_out_data", out_data, (i % 2) == 0 ? 8'h5A : 8'h3C);
            check("t31_hold_ready", {in0_ready, in1_ready}, 2'b00);
            @(negedge clk);
            check("t31_idle", out_valid, 1'b0);
        end
        clear_inputs();

        // Back-pressure: held result stays stable
        do_reset();
        in1_valid = 1'b1; in1_data = 8'hF0; in1_op = 2'd0;
        #1;
        check("t32_in1_ready", in1_ready, 1'b1);
        @(negedge clk);
        in0_valid = 1'b1; in0_data = 8'h11; in1_data = 8'h22;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t32_out_valid", out_valid, 1'b1);
            check("t32_out_data", out_data, 8'hF0);
            check("t32_out_id", out_id, 1'b1);
            check("t32_readies", {in0_ready, in1_ready}, 2'b00);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t32_released", out_valid, 1'b0);
        check("t32_next_grant0", in0_ready, 1'b1);
        clear_inputs();

        // Asynchronous reset while holding a result
        do_reset();
        in0_valid = 1'b1; in0_data = 8'h0F; in0_op = 2'd0;
        @(negedge clk);
        in0_valid = 1'b0;
        check("t33_hold", out_valid, 1'b1);
        check("t33_hold_data", out_data, 8'h0F);
        #2;
        rst_n = 1'b0;
        #1;
        check("t33_async_valid", out_valid, 1'b0);
        check("t33_async_data", out_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        in0_valid = 1'b1; in1_valid = 1'b1;
        #1;
        check("t33_tie_in0", in0_ready, 1'b1);
        check("t33_tie_in1", in1_ready, 1'b0);
        clear_inputs();

        // Inputs only sampled on the accepting edge
        do_reset();
        in0_valid = 1'b1; in0_data = 8'h12; in0_op = 2'd1;
        @(negedge clk);
        in0_data = 8'hFF; in0_op = 2'd0;
        @(negedge clk);
        in0_data = 8'h55; in0_op = 2'd2;
        @(negedge clk);
        in0_data = 8'h96; in0_op = 2'd3;
        check("t35_hold_data", out_data, 8'h48);
        out_ready = 1'b1;
        @(negedge clk);
        check("t35_idle", out_valid, 1'b0);
        @(negedge clk);
        check("t35_second_data", out_data, 8'h69);
        check("t35_second_valid", out_valid, 1'b1);
        clear_inputs();

`ifdef BITPERM_ARB_STATS_EN
        // Saturating counters with CW=2
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in0_valid = 1'b1; in0_data = 8'(i); in0_op = 2'd0;
            @(negedge clk);
            in0_valid = 1'b0;
            @(negedge clk);
            check("t34_cnt0", cnt0, (i < 3) ? i + 1 : 3);
            check("t34_cnt1", cnt1, 0);
        end
        clear_inputs();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bitperm_arbiter.md
BITPERM_ARBITER -- requirements
Module: bitperm_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the data width in bits; legal values are even and at least 2.
REQ-002 The block SHALL have parameter CW, default 16, giving the statistics counter width.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in0_valid, input, 1 bit: requester 0 has a pending job.
REQ-006 Port in0_ready, output, 1 bit: requester 0 job is accepted this cycle.
REQ-007 Port in0_data, input, W bits: requester 0 operand.
REQ-008 Port in0_op, input, 2 bits: requester 0 permutation select.
REQ-009 Ports in1_valid, in1_ready, in1_data and in1_op SHALL be identical to the requester 0 ports, for requester 1.
REQ-010 Port out_valid, output, 1 bit: result is held and valid.
REQ-011 Port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 Port out_data, output, W bits: permuted result.
REQ-013 Port out_id, output, 1 bit: index of the requester that produced the result.
REQ-014 Port cnt0, output, CW bits, present only with BITPERM_ARB_STATS_EN: requester 0 completed-job count.
REQ-015 Port cnt1, output, CW bits, present only with BITPERM_ARB_STATS_EN: requester 1 completed-job count.

Function
REQ-016 The permutation unit SHALL be a single unit shared by both requesters. It SHALL produce out[k] per op as follows:
- op 0: identity, out[k]=in[k].
- op 1: bit reverse, out[k]=in[W-1-k].
- op 2: half swap, out[W-1:W/2]=in[W/2-1:0] and out[W/2-1:0]=in[W-1:W/2].
- op 3: adjacent-pair swap, out[2j]=in[2j+1] and out[2j+1]=in[2j].
REQ-017 The FSM SHALL have two states: IDLE (no result held) and HOLD (result held).
REQ-018 In IDLE, exactly one inX_ready SHALL be high, and only when that requester's valid is high; in HOLD, both ready outputs SHALL be low.
REQ-019 Arbitration SHALL be round-robin:
- If one requester is valid, it is granted.
- If both are valid, the requester not served by the last accepted job is granted.
- After reset, requester 0 wins a tie.
REQ-020 On an accepted transfer (valid and ready), the next edge SHALL do all of the following: register the permuted data into out_data, register the requester index into out_id, set the last-served pointer, set out_valid=1, and move to HOLD. Latency is 1 cycle.
REQ-021 In HOLD, out_valid, out_data and out_id SHALL stay stable until out_ready=1; on the edge where out_valid and out_ready are both high, the FSM SHALL return to IDLE with out_valid=0.
REQ-022 No input SHALL be accepted in the same cycle a result is released; peak throughput is one job per 2 cycles.
REQ-023 inX_data and inX_op SHALL be sampled only on the accepting edge; input changes while not ready SHALL have no effect.
REQ-024 Any op value SHALL be legal; no X-propagation from unused ops.

Reset
REQ-025 While rst_n=0, the block SHALL hold: FSM=IDLE, out_valid=0, out_data=0, out_id=0, last-served pointer=1 (requester 0 wins first tie), and cnt0=cnt1=0.
REQ-026 Reset asserted in HOLD SHALL discard the held result immediately, without waiting for a clock edge.
REQ-027 After rst_n deasserts, the first acceptance SHALL occur no earlier than the first rising edge.

Configuration
REQ-028 With BITPERM_ARB_STATS_EN defined, cnt0 and cnt1 SHALL exist. cntX SHALL increment by 1 on each output handshake whose out_id=X, and SHALL saturate at 2^CW-1 (no wrap).
REQ-029 Without BITPERM_ARB_STATS_EN, the counters and their ports SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 W=8, only in0 valid with data 8'b1000_0001 and op 1, out_ready=1 -> in0_ready=1; the next cycle gives out_valid=1, out_data=8'b1000_0001, out_id=0; IDLE two cycles after acceptance.
REQ-031 Both valid and held continuously, with in0 = 8'hA5 op 2 and in1 = 8'h3C op 3, out_ready=1 -> grants alternate 0,1,0,1 starting with 0; outputs alternate 8'h5A and 8'h3C; one result every 2 cycles.
REQ-032 in1 = 8'hF0 op 0 accepted, out_ready=0 for 5 cycles -> out_data=8'hF0 and out_id=1 stable; both readies low throughout; release on the first cycle out_ready=1.
REQ-033 Reset pulsed while in HOLD with out_valid=1 -> out_valid=0 immediately; first grant after reset goes to requester 0 when both are valid.
REQ-034 With BITPERM_ARB_STATS_EN and CW=2, 5 completed requester-0 jobs -> cnt0 reads 1,2,3,3,3 and cnt1 stays 0.
REQ-035 in0 changes data and op each cycle while the block is in HOLD -> the later output equals the permutation of the value present on the accepting edge only.
